score_keeper: RTL and testbench
===============================

# score_keeper

Game-score datapath feeding the 8-digit seven-segment display controller. Accumulates points from gameplay hit/miss events with a combo multiplier, saturates at the 8-digit decimal limit, tracks the session high score, and drives the 32-bit binary score bus the display stage converts to decimal. A three-state game FSM (IDLE/PLAY/OVER) selects what the bus shows.

## Interface
- `COMBO_TIMEOUT`, default 50_000_000: cycles allowed between hits before the combo breaks.
- `HITS_PER_STEP`, default 4: consecutive hits per multiplier increment.
- `MAX_MULT`, default 4: multiplier ceiling, 1..7.
- `SHOW_CYCLES`, default 100_000_000: dwell per alternation in OVER.
- `CLK`  in  1  system clock. Single clock domain.
- `RST`  in  1  reset: synchronous, active-high.
- `START`  in  1  single-cycle pulse: begin or restart a game.
- `HIT`  in  1  single-cycle pulse: scoring event.
- `HIT_POINTS`  in  8  base points for `HIT`, sampled the same cycle.
- `MISS`  in  1  single-cycle pulse: breaks the combo.
- `GAME_OVER`  in  1  single-cycle pulse: end the game.
- `BINARY_SCORE`  out  32  registered value to the display controller.
- `HIGH_SCORE`  out  32  registered session best.
- `MULT`  out  3  current multiplier, 1..MAX_MULT.
- `STATE`  out  2  0=IDLE, 1=PLAY, 2=OVER.
- `NEW_HIGH`  out  1  level: last finished game set a new high score.

## Operation
- Reset values: state IDLE, score 0, `BINARY_SCORE` 0, `HIGH_SCORE` 0, `MULT` 1, hit count 0, timer 0, `NEW_HIGH` 0.
- IDLE: `BINARY_SCORE` shows `HIGH_SCORE`. `HIT`/`MISS`/`GAME_OVER` are ignored. `START` clears score, multiplier and hit count, clears `NEW_HIGH`, and moves to PLAY.
- PLAY:
  - `HIT`: score += `HIT_POINTS`*`MULT` using the multiplier from before this event. The sum saturates at MAX_SCORE = 99_999_999. The combo timer reloads to `COMBO_TIMEOUT`. Hit count increments; when it reaches `HITS_PER_STEP` it clears and `MULT` increments, capped at `MAX_MULT`.
  - `MISS`, or the timer expiring (reaching 0 with hit count > 0 or `MULT` > 1): `MULT` goes to 1 and hit count clears.
  - `HIT` and `MISS` in the same cycle: points are added at the old multiplier, then the combo resets.
  - `HIT_POINTS` = 0 still counts as a hit for the combo.
  - `START` in PLAY restarts the game, same as from IDLE.
  - `GAME_OVER` has priority over `HIT`/`MISS` in the same cycle: that cycle's hit is not scored. State moves to OVER. If score > `HIGH_SCORE`, `HIGH_SCORE` takes the score and `NEW_HIGH` is set. A tie does not count as a new high.
- OVER: score is frozen. `BINARY_SCORE` alternates between final score (first) and `HIGH_SCORE`, each held for `SHOW_CYCLES`. `START` begins a new game. There is no return to IDLE except through reset.
- Arithmetic: the 8x3-bit product is at most 11 bits. The adder is 32-bit and compared against MAX_SCORE, so the score never wraps.

## Timing
- All outputs are registered. `BINARY_SCORE`, `MULT` and `STATE` reflect an event on the cycle after it is sampled (1-cycle latency).
- `HIGH_SCORE` and `NEW_HIGH` update on the same edge as the transition into OVER.
- The alternation counter starts at 0 on OVER entry. The first swap to `HIGH_SCORE` happens `SHOW_CYCLES` cycles after entry.
- `RST` asserted on any edge overrides all inputs, including mid-game and mid-alternation. It also clears `HIGH_SCORE`.
- Inputs are assumed already synchronized and debounced upstream. A pulse held longer than one cycle counts once per cycle it is high.

## Configuration
- `SCORE_HISCORE_EN` defined: high-score register, `NEW_HIGH`, IDLE display of the high score, and OVER alternation are all compiled in.
- Not defined: `HIGH_SCORE` is tied to 0 and `NEW_HIGH` to 0. IDLE shows 0. OVER shows the final score steadily. The alternation counter and comparator are not built.

## Structure
- Shared package `score_pkg`: state encoding constants (IDLE/PLAY/OVER), MAX_SCORE, and the `STATE` width.
- One sub-module, `combo_tracker`: owns the timeout counter, hit count and multiplier. Its inputs are hit, miss and clear; its output is `MULT`. `score_keeper` holds the FSM, saturating adder, high-score register and display mux.

## Test plan
- Reset, then `START`, then `HIT` with points=10 five times (gap 10 cycles, `HITS_PER_STEP`=4): `BINARY_SCORE` = 10,20,30,40,60 and `MULT` is 2 after the 4th hit.
- Score 99_999_990, `MULT`=4, `HIT` points=200: `BINARY_SCORE` = 99_999_999. A further hit leaves it unchanged.
- `HIT` and `MISS` in the same cycle at `MULT`=3, points=5: score +15, `MULT` goes to 1, hit count 0.
- Combo timeout (sim `COMBO_TIMEOUT`=20): a hit at `MULT`=2 followed by 20 idle cycles makes `MULT` return to 1. A hit after 19 cycles keeps `MULT` at 2.
- `GAME_OVER` together with `HIT` at score 500 vs high 300: score stays 500, `HIGH_SCORE`=500, `NEW_HIGH`=1. Output alternates 500/500. A next game ending at 500 leaves `NEW_HIGH`=0.
- `RST` mid-PLAY and mid-OVER alternation: all outputs at reset values on the next cycle. Without `SCORE_HISCORE_EN`, OVER holds the final score steadily.

Source files
------------

// File: rtl/score_pkg.sv
// Shared encodings and limits for the score_keeper datapath.
package score_pkg;
  localparam int          STATE_W   = 2;
  localparam logic [31:0] MAX_SCORE = 32'd99_999_999;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;
endpackage

// File: rtl/score_keeper_combo_tracker.sv
// Combo bookkeeping: hit counter, multiplier and down-counting combo timer.
module combo_tracker #(
  parameter int COMBO_TIMEOUT = 50_000_000,
  parameter int HITS_PER_STEP = 4,
  parameter int MAX_MULT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       miss,
  input  logic       clear,
  output logic [2:0] mult
);
  localparam int TW = $clog2(COMBO_TIMEOUT + 1);
  localparam int CW = $clog2(HITS_PER_STEP + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(COMBO_TIMEOUT);
  localparam logic [CW-1:0] STEP_LAST  = CW'(HITS_PER_STEP - 1);
  localparam logic [2:0]    MULT_CAP   = 3'(MAX_MULT);

  logic [TW-1:0] timer;
  logic [CW-1:0] hit_cnt;
  logic          expire;

  // The combo breaks on the edge where the timer would reach zero.
  assign expire = !hit && (timer == TW'(1)) && ((hit_cnt != '0) || (mult != 3'd1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer   <= '0;
      hit_cnt <= '0;
      mult    <= 3'd1;
    end else if (hit) begin
      timer <= TIMER_LOAD;
      if (miss) begin
        hit_cnt <= '0;
        mult    <= 3'd1;
      end else if (hit_cnt == STEP_LAST) begin
        hit_cnt <= '0;
        if (mult < MULT_CAP) mult <= mult + 3'd1;
      end else begin
        hit_cnt <= hit_cnt + CW'(1);
      end
    end else if (miss || expire) begin
      timer   <= '0;
      hit_cnt <= '0;
      mult    <= 3'd1;
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end
endmodule

// File: rtl/score_keeper.sv
// Game score datapath: FSM, saturating adder, high score and display mux.
// Define SCORE_HISCORE_EN to build the high-score register and OVER alternation.
//   state | meaning
//   IDLE  | waiting for START, bus shows high score
//   PLAY  | scoring hits, bus shows live score
//   OVER  | score frozen, bus alternates final/high score
module score_keeper
  import score_pkg::*;
#(
  parameter int COMBO_TIMEOUT = 50_000_000,
  parameter int HITS_PER_STEP = 4,
  parameter int MAX_MULT      = 4,
  parameter int SHOW_CYCLES   = 100_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               HIT,
  input  logic [7:0]         HIT_POINTS,
  input  logic               MISS,
  input  logic               GAME_OVER,
  output logic [31:0]        BINARY_SCORE,
  output logic [31:0]        HIGH_SCORE,
  output logic [2:0]         MULT,
  output logic [STATE_W-1:0] STATE,
  output logic               NEW_HIGH
);
  state_t      state, state_next;
  logic [31:0] score, score_next, bin_next, sum;
  logic [10:0] product;
  logic        play, hit_eff, miss_eff;

  assign play     = (state == ST_PLAY);
  assign hit_eff  = play && HIT && !START && !GAME_OVER;
  assign miss_eff = play && MISS && !START && !GAME_OVER;
  assign product  = 11'(HIT_POINTS) * 11'(MULT);
  assign sum      = score + 32'(product);

  combo_tracker #(
    .COMBO_TIMEOUT(COMBO_TIMEOUT),
    .HITS_PER_STEP(HITS_PER_STEP),
    .MAX_MULT     (MAX_MULT)
  ) u_combo (
    .clk  (CLK),
    .rst  (RST),
    .hit  (hit_eff),
    .miss (miss_eff),
    .clear(START),
    .mult (MULT)
  );

  always_comb begin
    state_next = state;
    score_next = score;
    if (START) begin
      state_next = ST_PLAY;
      score_next = '0;
    end else if (play && GAME_OVER) begin
      state_next = ST_OVER;
    end else if (hit_eff) begin
      score_next = (sum > MAX_SCORE) ? MAX_SCORE : sum;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      score        <= '0;
      BINARY_SCORE <= '0;
    end else begin
      state        <= state_next;
      score        <= score_next;
      BINARY_SCORE <= bin_next;
    end
  end

  assign STATE = state;

`ifdef SCORE_HISCORE_EN
  localparam int SW = $clog2(SHOW_CYCLES + 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);

  logic [31:0]   high_next;
  logic          new_high_next, show_high, show_high_next;
  logic [SW-1:0] alt_cnt, alt_cnt_next;

  always_comb begin
    high_next      = HIGH_SCORE;
    new_high_next  = NEW_HIGH;
    show_high_next = show_high;
    alt_cnt_next   = alt_cnt;
    if (START) begin
      new_high_next = 1'b0;
    end else if (play && GAME_OVER && (score > HIGH_SCORE)) begin
      high_next     = score;
      new_high_next = 1'b1;
    end
    // Alternation restarts from the final score on every entry into OVER.
    if ((state != ST_OVER) || (state_next != ST_OVER)) begin
      alt_cnt_next   = '0;
      show_high_next = 1'b0;
    end else if (alt_cnt == SHOW_LAST) begin
      alt_cnt_next   = '0;
      show_high_next = !show_high;
    end else begin
      alt_cnt_next = alt_cnt + SW'(1);
    end
    case (state_next)
      ST_IDLE: bin_next = high_next;
      ST_OVER: bin_next = show_high_next ? high_next : score_next;
      default: bin_next = score_next;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HIGH_SCORE <= '0;
      NEW_HIGH   <= 1'b0;
      show_high  <= 1'b0;
      alt_cnt    <= '0;
    end else begin
      HIGH_SCORE <= high_next;
      NEW_HIGH   <= new_high_next;
      show_high  <= show_high_next;
      alt_cnt    <= alt_cnt_next;
    end
  end
`else
  logic unused_show;

  assign unused_show = (SHOW_CYCLES > 0);
  assign HIGH_SCORE  = '0;
  assign NEW_HIGH    = 1'b0;
  assign bin_next    = (state_next == ST_IDLE) ? 32'd0 : score_next;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: event-level reference model checked every cycle,
// plus hand-computed checkpoints. Follows SCORE_HISCORE_EN when it is defined.
module tb_score_keeper;
  localparam int    CT   = 20;
  localparam int    HPS  = 4;
  localparam int    MM   = 7;
  localparam int    SC   = 8;
  localparam longint MAXS = 99_999_999;
`ifdef SCORE_HISCORE_EN
  localparam bit HISC = 1'b1;
`else
  localparam bit HISC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, START, HIT, MISS, GAME_OVER;
  logic [7:0]  HIT_POINTS;
  logic [31:0] BINARY_SCORE, HIGH_SCORE;
  logic [2:0]  MULT;
  logic [1:0]  STATE;
  logic        NEW_HIGH;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (event level)
  bit     m_valid = 0;
  int     m_state = 0;
  longint m_score = 0, m_high = 0;
  int     m_newhigh = 0, m_mult = 1, m_hits = 0, m_idle = 0, m_over = 0;

  score_keeper #(
    .COMBO_TIMEOUT(CT), .HITS_PER_STEP(HPS), .MAX_MULT(MM), .SHOW_CYCLES(SC)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .HIT(HIT), .HIT_POINTS(HIT_POINTS),
    .MISS(MISS), .GAME_OVER(GAME_OVER), .BINARY_SCORE(BINARY_SCORE),
    .HIGH_SCORE(HIGH_SCORE), .MULT(MULT), .STATE(STATE), .NEW_HIGH(NEW_HIGH)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint m_bin();
    if (m_state == 0) return HISC ? m_high : 0;
    if (m_state == 1) return m_score;
    if (HISC && ((m_over / SC) % 2 == 1)) return m_high;
    return m_score;
  endfunction

  task automatic model_step();
    bit h, m;
    if (RST) begin
      m_state = 0; m_score = 0; m_high = 0; m_newhigh = 0;
      m_mult = 1; m_hits = 0; m_idle = 0; m_over = 0; m_valid = 1;
      return;
    end
    h = (m_state == 1) && HIT && !START && !GAME_OVER;
    m = (m_state == 1) && MISS && !START && !GAME_OVER;
    if (START) begin
      m_state = 1; m_score = 0; m_mult = 1; m_hits = 0; m_idle = 0; m_newhigh = 0;
      return;
    end
    if (m_state == 1 && GAME_OVER) begin
      m_state = 2; m_over = 0;
      if (HISC && m_score > m_high) begin m_high = m_score; m_newhigh = 1; end
    end else if (m_state == 2) begin
      m_over++;
    end
    if (h) begin
      m_score = m_score + longint'(HIT_POINTS) * m_mult;
      if (m_score > MAXS) m_score = MAXS;
      m_idle = 0;
      m_hits++;
      if (m_hits == HPS) begin
        m_hits = 0;
        if (m_mult < MM) m_mult++;
      end
    end else begin
      m_idle++;
    end
    if (m) begin
      m_mult = 1; m_hits = 0;
    end else if (!h && m_idle == CT && (m_hits > 0 || m_mult > 1)) begin
      m_mult = 1; m_hits = 0;
    end
  endtask

  // compare last edge's outputs, then advance the model with the inputs for the next edge
  initial forever begin
    @(negedge CLK);
    if (m_valid) begin
      chk("bin",      BINARY_SCORE, 32'(m_bin()));
      chk("high",     HIGH_SCORE,   32'(m_high));
      chk("mult",     32'(MULT),    32'(m_mult));
      chk("state",    32'(STATE),   32'(m_state));
      chk("new_high", 32'(NEW_HIGH), 32'(m_newhigh));
    end
    model_step();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: dut=running expected=finished");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask
  task automatic pulse_hit(input int pts);
    HIT = 1; HIT_POINTS = 8'(pts); cyc(); HIT = 0;
  endtask
  task automatic pulse_start();
    START = 1; cyc(); START = 0;
  endtask
  task automatic pulse_go();
    GAME_OVER = 1; cyc(); GAME_OVER = 0;
  endtask
  task automatic pulse_miss();
    MISS = 1; cyc(); MISS = 0;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_bin"},   BINARY_SCORE, 0);
    chk({nm, "_high"},  HIGH_SCORE, 0);
    chk({nm, "_mult"},  32'(MULT), 1);
    chk({nm, "_state"}, 32'(STATE), 0);
    chk({nm, "_nh"},    32'(NEW_HIGH), 0);
  endtask

  initial begin
    RST = 1; START = 0; HIT = 0; HIT_POINTS = 0; MISS = 0; GAME_OVER = 0;
    cyc(); cyc(); RST = 0;
    chk_reset("reset");

    // IDLE ignores gameplay pulses
    pulse_hit(50); pulse_miss(); pulse_go();
    chk("idle_bin", BINARY_SCORE, 0);
    chk("idle_state", 32'(STATE), 0);

    pulse_start();
    chk("start_state", 32'(STATE), 1);
    for (int i = 0; i < 5; i++) begin
      pulse_hit(10);
      chk("hit10_bin", BINARY_SCORE, (i == 4) ? 60 : 10 * (i + 1));
      if (i == 3) chk("mult_after4", 32'(MULT), 2);
      if (i < 4) repeat (9) cyc();
    end

    // combo timer boundary: 19 idle cycles keeps it, 20 breaks it
    repeat (19) cyc();
    pulse_hit(0);
    chk("timeout19_mult", 32'(MULT), 2);
    repeat (19) cyc();
    chk("idle19_mult", 32'(MULT), 2);
    cyc();
    chk("timeout20_mult", 32'(MULT), 1);

    repeat (8) pulse_hit(0);
    chk("mult3", 32'(MULT), 3);
    HIT = 1; MISS = 1; HIT_POINTS = 5; cyc(); HIT = 0; MISS = 0;
    chk("hitmiss_bin", BINARY_SCORE, 75);
    chk("hitmiss_mult", 32'(MULT), 1);
    repeat (3) pulse_hit(0);
    chk("cnt_cleared_mult", 32'(MULT), 1);
    pulse_hit(0);
    chk("cnt_step_mult", 32'(MULT), 2);
    pulse_miss();
    pulse_hit(225);
    chk("score300", BINARY_SCORE, 300);
    pulse_go();
    chk("over_state", 32'(STATE), 2);
    chk("over_high300", HIGH_SCORE, HISC ? 300 : 0);
    chk("over_nh1", 32'(NEW_HIGH), HISC ? 1 : 0);
    repeat (3) cyc();

    // game ending with GAME_OVER+HIT: hit is dropped
    pulse_start();
    chk("restart_nh", 32'(NEW_HIGH), 0);
    pulse_hit(250); pulse_hit(250);
    chk("score500", BINARY_SCORE, 500);
    HIT = 1; HIT_POINTS = 100; GAME_OVER = 1; cyc(); HIT = 0; GAME_OVER = 0;
    chk("go_hit_bin", BINARY_SCORE, 500);
    chk("go_hit_high", HIGH_SCORE, HISC ? 500 : 0);
    chk("go_hit_nh", 32'(NEW_HIGH), HISC ? 1 : 0);
    repeat (SC) cyc();
    chk("alt_500", BINARY_SCORE, 500);

    // tie is not a new high
    pulse_start();
    pulse_hit(250); pulse_hit(250);
    pulse_go();
    chk("tie_nh", 32'(NEW_HIGH), 0);
    chk("tie_high", HIGH_SCORE, HISC ? 500 : 0);

    // alternation then reset mid-OVER
    pulse_start();
    pulse_hit(123);
    pulse_go();
    chk("final123", BINARY_SCORE, 123);
    repeat (SC - 1) cyc();
    chk("before_swap", BINARY_SCORE, 123);
    cyc();
    chk("after_swap", BINARY_SCORE, HISC ? 500 : 123);
    repeat (2) cyc();
    RST = 1; cyc(); RST = 0;
    chk_reset("rst_over");

    // saturation with HIT held high
    pulse_start();
    HIT = 1; HIT_POINTS = 255;
    for (int n = 0; n < 70000 && m_score != MAXS; n++) cyc();
    HIT = 0;
    chk("sat_bin", BINARY_SCORE, 32'(MAXS));
    chk("sat_mult", 32'(MULT), MM);
    pulse_hit(255);
    chk("sat_hold", BINARY_SCORE, 32'(MAXS));
    RST = 1; cyc(); RST = 0;
    chk_reset("rst_play");

    // START in PLAY restarts even with a simultaneous hit
    pulse_start();
    pulse_hit(10);
    chk("pre_restart", BINARY_SCORE, 10);
    START = 1; HIT = 1; HIT_POINTS = 10; cyc(); START = 0; HIT = 0;
    chk("restart_bin", BINARY_SCORE, 0);
    chk("restart_state", 32'(STATE), 1);
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
